// File: rtl/adder_tree_sched_if.sv
// Signal bundle between the requesters, the shared adder tree and the result
// consumer of adder_tree_sched. The scheduler takes the slave side.
interface adder_tree_sched_if #(
  parameter int DATA_W   = 16,
  parameter int DATA_N   = 10,
  parameter int NUM_REQ  = 2,
  parameter int TREE_LAT = 4
);
  localparam int SUM_W = DATA_W + TREE_LAT;
  localparam int ID_W  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*DATA_N*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             flush;
  logic [DATA_N*DATA_W-1:0]         tree_data;
  logic [SUM_W-1:0]                 tree_sum;
  logic                             res_valid;
  logic [ID_W-1:0]                  res_id;
  logic [SUM_W-1:0]                 res_sum;
  logic [15:0]                      issue_cnt;

  modport master (
    output req_valid, req_data, flush, tree_sum,
    input  req_ready, tree_data, res_valid, res_id, res_sum, issue_cnt
  );

  modport slave (
    input  req_valid, req_data, flush, tree_sum,
    output req_ready, tree_data, res_valid, res_id, res_sum, issue_cnt
  );
endinterface

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one external pipelined adder tree among several
// requesters; a valid/ID tag pipe tracks each vector through the tree latency.
module adder_tree_sched #(
  parameter int DATA_W   = 16,
  parameter int DATA_N   = 10,
  parameter int NUM_REQ  = 2,
  parameter int TREE_LAT = 4
) (
  input logic clk,
  input logic rst,
  adder_tree_sched_if.slave bus
);
  localparam int ID_W  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VEC_W = DATA_N * DATA_W;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic              hi_any;
  logic [ID_W-1:0]   hi_id;
  logic              lo_any;
  logic [ID_W-1:0]   lo_id;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic              handshake;
  logic [VEC_W-1:0]  grant_vec;
  logic [VEC_W-1:0]  tree_data_q;
  logic [TREE_LAT:0] tag_valid;
  logic [ID_W-1:0]   tag_id [TREE_LAT+1];
  logic [15:0]       issue_cnt_q;

  // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_any = 1'b0;
    hi_id  = '0;
    lo_any = 1'b0;
    lo_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_any = 1'b1;
        lo_id  = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          hi_any = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
    grant_any = lo_any;
    grant_id  = hi_any ? hi_id : lo_id;
  end

  assign handshake = grant_any & ~bus.flush;
  assign ptr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    bus.req_ready = '0;
    grant_vec     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        bus.req_ready[i] = handshake;
        grant_vec        = bus.req_data[i*VEC_W +: VEC_W];
      end
    end
  end

  // tree_data only loads on a handshake so idle cycles do not toggle the tree inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      tree_data_q <= '0;
      issue_cnt_q <= '0;
      tag_valid   <= '0;
      for (int s = 0; s <= TREE_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      if (handshake) begin
        ptr         <= ptr_next;
        tree_data_q <= grant_vec;
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
      tag_valid <= bus.flush ? '0 : {tag_valid[TREE_LAT-1:0], handshake};
      tag_id[0] <= grant_id;
      for (int s = 1; s <= TREE_LAT; s++) begin
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign bus.tree_data = tree_data_q;
  assign bus.res_valid = tag_valid[TREE_LAT];
  assign bus.res_id    = tag_id[TREE_LAT];
  assign bus.res_sum   = bus.tree_sum;
  assign bus.issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_adder_tree_sched.sv
// Self-checking bench for adder_tree_sched: emulates the external adder tree and
// predicts grants and results with a queue-based reference model.
module tb_adder_tree_sched;
  localparam int DATA_W   = 16;
  localparam int DATA_N   = 10;
  localparam int NUM_REQ  = 2;
  localparam int TREE_LAT = 4;
  localparam int SUM_W    = DATA_W + TREE_LAT;
  localparam int ID_W     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VEC_W    = DATA_N * DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_tree_sched_if #(.DATA_W(DATA_W), .DATA_N(DATA_N), .NUM_REQ(NUM_REQ), .TREE_LAT(TREE_LAT)) bus ();
  adder_tree_sched #(.DATA_W(DATA_W), .DATA_N(DATA_N), .NUM_REQ(NUM_REQ), .TREE_LAT(TREE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  adder_tree_sched_if #(.DATA_W(DATA_W), .DATA_N(DATA_N), .NUM_REQ(3), .TREE_LAT(TREE_LAT)) bus3 ();
  adder_tree_sched #(.DATA_W(DATA_W), .DATA_N(DATA_N), .NUM_REQ(3), .TREE_LAT(TREE_LAT)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );
  assign bus3.tree_sum = '0;

  function automatic logic [SUM_W-1:0] tree_add(logic [VEC_W-1:0] v);
    int acc;
    acc = 0;
    for (int i = 0; i < DATA_N; i++) acc += int'($signed(v[i*DATA_W +: DATA_W]));
    return SUM_W'(acc);
  endfunction

  // Stand-in for the external tree: TREE_LAT registers after tree_data.
  logic [SUM_W-1:0] tree_pipe [TREE_LAT];
  always @(posedge clk) begin
    tree_pipe[0] <= tree_add(bus.tree_data);
    for (int k = 1; k < TREE_LAT; k++) tree_pipe[k] <= tree_pipe[k-1];
  end
  assign bus.tree_sum = tree_pipe[TREE_LAT-1];

  typedef struct {
    int               due;
    int               id;
    logic [SUM_W-1:0] sum;
  } exp_t;

  exp_t m_q[$];
  int   m_ptr;
  int   m_cnt;
  int   cyc;
  int   total;
  int   bad;

  function automatic logic [VEC_W-1:0] fill(logic [DATA_W-1:0] x);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < DATA_N; i++) v[i*DATA_W +: DATA_W] = x;
    return v;
  endfunction

  function automatic logic [NUM_REQ*VEC_W-1:0] rand_data();
    logic [NUM_REQ*VEC_W-1:0] d;
    for (int i = 0; i < NUM_REQ * DATA_N; i++) d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  function automatic logic [SUM_W-1:0] vec_sum(int r);
    logic [NUM_REQ*VEC_W-1:0] all;
    all = bus.req_data;
    return tree_add(VEC_W'(all >> (r * VEC_W)));
  endfunction

  // Requester closest (in rotation distance) after the pointer wins.
  function automatic int m_grant();
    int best;
    int best_off;
    int off;
    best     = -1;
    best_off = NUM_REQ;
    if (bus.flush) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i]) begin
        off = (i - m_ptr + NUM_REQ) % NUM_REQ;
        if (off < best_off) begin
          best_off = off;
          best     = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [NUM_REQ-1:0] m_ready();
    logic [NUM_REQ-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    for (int i = 0; i < NUM_REQ; i++) if (i == g) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic m_rv();
    if (m_q.size() == 0) return 1'b0;
    return m_q[0].due == cyc;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic m_commit();
    int g;
    g = m_grant();
    if (m_rv()) void'(m_q.pop_front());
    if (bus.flush) m_q.delete();
    if (g >= 0) begin
      exp_t e;
      e.due = cyc + TREE_LAT + 1;
      e.id  = g;
      e.sum = vec_sum(g);
      m_q.push_back(e);
      m_ptr = (g + 1) % NUM_REQ;
      m_cnt = (m_cnt + 1) % 65536;
    end
    cyc++;
  endtask

  task automatic finish_cycle();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_valid: got %0b want 0", bus.res_valid); end
    total++; if (bus.res_id !== ID_W'(0)) begin bad++; $display("[TB] FAIL reset_res_id: got %0d want 0", bus.res_id); end
    total++; if (bus.tree_data !== '0) begin bad++; $display("[TB] FAIL reset_tree_data: got %0h want 0", bus.tree_data); end
    total++; if (bus.issue_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_issue_cnt: got %0d want 0", bus.issue_cnt); end
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL reset_ready: got %b want 01", bus.req_ready); end
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    bus.req_data  = {fill(16'd0), fill(16'd1)};
    bus.req_valid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_ready: got %b want 01", bus.req_ready); end
      end
      total++; if (bus.res_valid !== (k == 5)) begin bad++; $display("[TB] FAIL single_valid c%0d: got %0b want %0b", k, bus.res_valid, (k == 5)); end
      if (k == 5) begin
        total++; if (bus.res_sum !== 20'd10) begin bad++; $display("[TB] FAIL single_sum: got %0h want a", bus.res_sum); end
        total++; if (bus.res_id !== ID_W'(0)) begin bad++; $display("[TB] FAIL single_id: got %0d want 0", bus.res_id); end
      end
      if (k == 7) begin
        total++; if (bus.issue_cnt !== 16'd1) begin bad++; $display("[TB] FAIL single_issue_cnt: got %0d want 1", bus.issue_cnt); end
      end
      finish_cycle();
      bus.req_valid = '0;
    end
  endtask

  task automatic test_signed_extremes();
    logic [DATA_W-1:0] vals [3];
    logic [SUM_W-1:0]  sums [3];
    vals = '{16'hFFFF, 16'h7FFF, 16'h8000};
    sums = '{20'hFFFF6, 20'h4FFF6, 20'hB0000};
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin
        bus.req_valid = 2'b01;
        bus.req_data  = {fill(16'h1234), fill(vals[k])};
      end else begin
        bus.req_valid = '0;
        bus.req_data  = rand_data();
      end
      @(negedge clk);
      total++; if (bus.res_valid !== (k >= 5 && k <= 7)) begin bad++; $display("[TB] FAIL signed_valid c%0d: got %0b", k, bus.res_valid); end
      if (k >= 5 && k <= 7) begin
        total++; if (bus.res_sum !== sums[k-5]) begin bad++; $display("[TB] FAIL signed_sum c%0d: got %0h want %0h", k, bus.res_sum, sums[k-5]); end
        total++; if (bus.res_id !== ID_W'(0)) begin bad++; $display("[TB] FAIL signed_id c%0d: got %0d want 0", k, bus.res_id); end
      end
      if (k >= 3) begin
        total++; if (bus.tree_data !== fill(16'h8000)) begin bad++; $display("[TB] FAIL signed_hold c%0d: got %0h want %0h", k, bus.tree_data, fill(16'h8000)); end
      end
      finish_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_REQ-1:0] prev_ready;
    prev_ready   = '0;
    bus.req_data = {fill(16'd3), fill(16'd2)};
    for (int c = 0; c < 20; c++) begin
      bus.req_valid = (c < 14) ? 2'b11 : 2'b00;
      @(negedge clk);
      total++; if (bus.req_ready !== m_ready()) begin bad++; $display("[TB] FAIL b2b_ready c%0d: got %b want %b", c, bus.req_ready, m_ready()); end
      if (c >= 1 && c < 14) begin
        total++; if (bus.req_ready === prev_ready) begin bad++; $display("[TB] FAIL b2b_alternate c%0d: got %b again, want change", c, bus.req_ready); end
      end
      prev_ready = bus.req_ready;
      total++; if (bus.res_valid !== m_rv()) begin bad++; $display("[TB] FAIL b2b_valid c%0d: got %0b want %0b", c, bus.res_valid, m_rv()); end
      if (m_rv()) begin
        total++; if (bus.res_id !== ID_W'(m_q[0].id)) begin bad++; $display("[TB] FAIL b2b_id c%0d: got %0d want %0d", c, bus.res_id, m_q[0].id); end
        total++; if (bus.res_sum !== m_q[0].sum) begin bad++; $display("[TB] FAIL b2b_sum c%0d: got %0h want %0h", c, bus.res_sum, m_q[0].sum); end
      end
      finish_cycle();
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 14; c++) begin
      bus.flush     = (c == 3);
      bus.req_valid = (c <= 3 || c == 5) ? 2'b01 : 2'b00;
      bus.req_data  = {fill(16'd9), fill((c == 5) ? 16'd7 : DATA_W'(c + 1))};
      @(negedge clk);
      if (c == 3) begin
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("[TB] FAIL flush_no_grant: got %b want 00", bus.req_ready); end
      end
      if (c == 5) begin
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL flush_regrant: got %b want 01", bus.req_ready); end
      end
      total++; if (bus.res_valid !== (c == 10)) begin bad++; $display("[TB] FAIL flush_valid c%0d: got %0b want %0b", c, bus.res_valid, (c == 10)); end
      if (c == 10) begin
        total++; if (bus.res_sum !== 20'd70) begin bad++; $display("[TB] FAIL flush_sum: got %0h want 46", bus.res_sum); end
      end
      finish_cycle();
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c < 392) begin
        bus.req_valid = NUM_REQ'($urandom);
        bus.flush     = ($urandom_range(0, 15) == 0);
      end else begin
        bus.req_valid = '0;
        bus.flush     = 1'b0;
      end
      bus.req_data = rand_data();
      @(negedge clk);
      total++; if (bus.req_ready !== m_ready()) begin bad++; $display("[TB] FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, m_ready()); end
      total++; if (bus.res_valid !== m_rv()) begin bad++; $display("[TB] FAIL rand_valid c%0d: got %0b want %0b", c, bus.res_valid, m_rv()); end
      if (m_rv()) begin
        total++; if (bus.res_id !== ID_W'(m_q[0].id)) begin bad++; $display("[TB] FAIL rand_id c%0d: got %0d want %0d", c, bus.res_id, m_q[0].id); end
        total++; if (bus.res_sum !== m_q[0].sum) begin bad++; $display("[TB] FAIL rand_sum c%0d: got %0h want %0h", c, bus.res_sum, m_q[0].sum); end
      end
      total++; if (bus.issue_cnt !== 16'(m_cnt)) begin bad++; $display("[TB] FAIL rand_issue_cnt c%0d: got %0d want %0d", c, bus.issue_cnt, m_cnt); end
      finish_cycle();
    end
  endtask

  task automatic test_reset_mid_flight();
    bus.req_data  = {fill(16'd5), fill(16'd4)};
    bus.req_valid = 2'b11;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++; if (bus.res_valid !== m_rv()) begin bad++; $display("[TB] FAIL midrst_pre_valid c%0d: got %0b want %0b", c, bus.res_valid, m_rv()); end
      finish_cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %0b want 0", bus.res_valid); end
    total++; if (bus.res_id !== ID_W'(0)) begin bad++; $display("[TB] FAIL midrst_id: got %0d want 0", bus.res_id); end
    total++; if (bus.tree_data !== '0) begin bad++; $display("[TB] FAIL midrst_tree_data: got %0h want 0", bus.tree_data); end
    total++; if (bus.issue_cnt !== 16'd0) begin bad++; $display("[TB] FAIL midrst_issue_cnt: got %0d want 0", bus.issue_cnt); end
    m_reset();
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_hold_valid: got %0b want 0", bus.res_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("[TB] FAIL midrst_first_grant: got %b want 01", bus.req_ready); end
    finish_cycle();
    bus.req_valid = '0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++; if (bus.res_valid !== m_rv()) begin bad++; $display("[TB] FAIL midrst_post_valid c%0d: got %0b want %0b", c, bus.res_valid, m_rv()); end
      if (m_rv()) begin
        total++; if (bus.res_sum !== m_q[0].sum) begin bad++; $display("[TB] FAIL midrst_post_sum: got %0h want %0h", bus.res_sum, m_q[0].sum); end
      end
      finish_cycle();
    end
  endtask

  task automatic test_three_req();
    int p3;
    int g;
    int n1;
    int n2;
    logic [2:0] exp_ready;
    p3 = 0;
    n1 = 0;
    n2 = 0;
    bus3.req_valid = 3'b110;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      g = -1;
      for (int off = 0; off < 3; off++) begin
        if (g < 0 && ((p3 + off) % 3) != 0) g = (p3 + off) % 3;
      end
      exp_ready = 3'(1 << g);
      total++; if (bus3.req_ready !== exp_ready) begin bad++; $display("[TB] FAIL three_ready c%0d: got %b want %b", c, bus3.req_ready, exp_ready); end
      if (bus3.req_ready[1]) n1++;
      if (bus3.req_ready[2]) n2++;
      p3 = (g + 1) % 3;
      @(posedge clk);
      #1;
    end
    bus3.req_valid = '0;
    @(negedge clk);
    total++; if (n1 != 10 || n2 != 10) begin bad++; $display("[TB] FAIL three_fairness: got %0d/%0d want 10/10", n1, n2); end
    total++; if (bus3.issue_cnt !== 16'd20) begin bad++; $display("[TB] FAIL three_issue_cnt: got %0d want 20", bus3.issue_cnt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_issue_wrap();
    rst = 1'b1;
    #1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_data  = {fill(16'd0), fill(16'd1)};
    for (int n = 0; n < 65536; n++) begin
      @(negedge clk);
      if (n == 65535) begin
        total++; if (bus.issue_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_pre: got %0h want ffff", bus.issue_cnt); end
      end
      finish_cycle();
    end
    bus.req_valid = '0;
    @(negedge clk);
    total++; if (bus.issue_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_zero: got %0h want 0", bus.issue_cnt); end
    finish_cycle();
    repeat (7) begin
      @(negedge clk);
      finish_cycle();
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    cyc            = 0;
    m_ptr          = 0;
    m_cnt          = 0;
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.flush      = 1'b0;
    bus3.req_valid = '0;
    bus3.req_data  = '0;
    bus3.flush     = 1'b0;
    $display("[TB] starting adder_tree_sched bench");
    test_reset();
    test_single();
    test_signed_extremes();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid_flight();
    test_three_req();
    test_issue_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_tree_sched.md
# adder_tree_sched

Round-robin scheduler that shares one pipelined adder tree (DATA_N inputs of DATA_W bits, one register per tree level) among NUM_REQ requesters in the LMS datapath. Typical requesters are the filter-output dot product and the error-weighted update sum. Each cycle it grants at most one requester and registers that requester's operand vector into the tree. It carries a valid/ID tag down a shift pipe matched to the tree latency and presents each tree result with its originating requester ID. The tree itself is instantiated outside this block.

## Interface
Parameters:
- DATA_W, 16, signed operand width
- DATA_N, 10, operands per vector, ≥2
- NUM_REQ, 2, requester count, ≥2
- TREE_LAT, 4, tree pipeline depth; must equal clogb2(DATA_N)
- SUM_W (localparam), DATA_W+TREE_LAT, result width
- ID_W (localparam), max(1, clogb2(NUM_REQ)), requester ID width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester vector valid
- req_data  in  NUM_REQ*DATA_N*DATA_W  requester i occupies slice [i*DATA_N*DATA_W +: DATA_N*DATA_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational
- flush  in  1  synchronous drop of all in-flight results
- tree_data  out  DATA_N*DATA_W  registered operand vector to the tree
- tree_sum  in  SUM_W  tree result
- res_valid  out  1  result strobe
- res_id  out  ID_W  requester that owns res_sum
- res_sum  out  SUM_W  signed result, equals tree_sum
- issue_cnt  out  16  accepted vectors since reset, wraps

## Operation
- Arbiter: priority rotates. Search starts at ptr and proceeds ptr, ptr+1, … mod NUM_REQ. The first requester with req_valid high is granted.
- req_ready[g]=1 only for the granted requester g. req_ready depends combinationally on req_valid. All req_ready bits are 0 when no requester is valid or flush=1.
- Handshake: req_valid[g] & req_ready[g]. On handshake:
  - tree_data ← slice g
  - ptr ← (g+1) mod NUM_REQ
  - tag pipe stage 0 ← {valid=1, id=g}
  - issue_cnt increments, wrapping at 0xFFFF→0
- No handshake: tree_data holds its value (no toggling); tag stage 0 ← valid=0.
- Tag pipe: TREE_LAT+1 stages of {valid, id}, shifting every cycle. There is no backpressure: the tree cannot stall, so consumers must accept res_* on every res_valid.
- Outputs: res_valid = last stage valid; res_id = last stage id; res_sum = tree_sum, passed through combinationally.
- flush=1: all tag-stage valids clear on the next edge and no grant is issued that cycle. Data already in the tree drains unobserved.
- Requester vectors must stay stable only during the handshake cycle.
- Arithmetic: two's complement throughout. The tree sign-extends, so SUM_W bits cannot overflow for any DATA_N vectors.

## Timing
- Reset values: tree_data=0, all tag valids=0, res_valid=0, res_id=0, ptr=0, issue_cnt=0. req_ready follows req_valid, with requester 0 at highest priority.
- Latency: a handshake in cycle T yields res_valid=1 in cycle T+TREE_LAT+1. That is 1 cycle for the issue register plus TREE_LAT cycles in the tree; 5 cycles with the defaults.
- Throughput: one vector per cycle. Results leave in issue order with no gaps beyond the gaps at the input.
- Simultaneous requests: exactly one grant per cycle. A continuously requesting requester is granted at least once every NUM_REQ cycles, so no starvation.
- flush in the same cycle as req_valid: no grant; the request waits for the next cycle.
- Reset mid-operation: all state clears immediately. In-flight results are never reported, even if tree_sum later carries stale data.
- ptr wrap: after requester NUM_REQ-1 is granted, ptr returns to 0.

## Test plan
1. Requester 0 only, all ten operands = 1 (defaults): handshake at T → res_valid high only at T+5, res_sum=10, res_id=0, issue_cnt=1.
2. Both requesters valid continuously, req0 vector all 2, req1 vector all 3: grants alternate 0,1,0,1. Back-to-back results alternate 20/id0 and 30/id1, with no bubbles.
3. Signed extremes: all 0xFFFF → res_sum=0xFFFF6 (−10, 20-bit). All 0x7FFF → 0x4FFF6. All 0x8000 → 0xB0000.
4. Issue 3 vectors, assert flush one cycle later: none of the 3 produce res_valid. A vector issued 2 cycles after flush returns normally 5 cycles later.
5. Assert rst asynchronously with 4 results in flight: res_valid, res_id and tree_data drop to 0 before the next edge. After release, req1 and req0 both valid → req0 granted first.
6. NUM_REQ=3, only requesters 1 and 2 valid for 20 cycles: grants alternate 1,2 with 10 each. issue_cnt wrap is checked by forcing 65536 handshakes → issue_cnt=0.
